// File: rtl/wb_writeback_pkg.sv
// Shared types and constants for the writeback stage: register/data types,
// load funct3 encodings and the pending-load queue entry.
package wb_writeback_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0]      r_t;

    localparam r_t    ZERO = '0;
    localparam data_t NULL = '0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        r_t         rd;
        logic       wren;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } ld_entry_t;

endpackage

// File: rtl/wb_writeback_load_align.sv
// Load data alignment: selects the byte/half addressed by addr_lo from an
// aligned word and sign/zero-extends it according to funct3.
module wb_load_align
    import wb_writeback_pkg::*;
(
    input  data_t      word_i,
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] funct3_i,
    output data_t      data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Misaligned halves use addr_lo[1] only; words ignore the offset.
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
            LH:      data_o = {{16{half_sel[15]}}, half_sel};
            LBU:     data_o = {24'd0, byte_sel};
            LHU:     data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: merges ALU results and in-order load responses onto the
// register-file write port and tracks pending load destinations for decode.
// Optional performance counters are built when WB_PERF_CNT_EN is defined.
module wb_writeback
    import wb_writeback_pkg::*;
#(
    parameter int unsigned LDQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_rd_wren,
    input  r_t          mem_rd_addr,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_lo,
    input  data_t       mem_alu_data,
    input  logic        ld_rsp_valid,
    input  data_t       ld_rsp_data,
    input  r_t          rs1_addr,
    input  r_t          rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_wren,
    output r_t          rd_addr,
    output data_t       rd_data,
    output logic        wb_err,
    output logic [31:0] wb_retire_cnt,
    output logic [31:0] wb_stall_cnt
);

    localparam int unsigned PW = $clog2(LDQ_DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    ld_entry_t              ent_q [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0]   vld_q, vld_d;
    ptr_t                   head_q, tail_q;
    cnt_t                   cnt_q, cnt_d;

    logic  skid_vld_q, skid_vld_d, skid_wren_q, skid_wren_d;
    r_t    skid_rd_q, skid_rd_d;
    data_t skid_data_q, skid_data_d;

    logic  rd_wren_q, rd_wren_d, err_q;
    r_t    rd_addr_q, rd_addr_d;
    data_t rd_data_q, rd_data_d;

    logic      waw_busy, q_full, q_empty, acc, push, pop, alu_acc;
    ld_entry_t head_ent;
    data_t     ld_data;

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        waw_busy = 1'b0;
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
            if (vld_q[i] && ent_q[i].wren) begin
                if (ent_q[i].rd == rs1_addr    && rs1_addr    != ZERO) rs1_busy = 1'b1;
                if (ent_q[i].rd == rs2_addr    && rs2_addr    != ZERO) rs2_busy = 1'b1;
                if (ent_q[i].rd == mem_rd_addr && mem_rd_addr != ZERO) waw_busy = 1'b1;
            end
        end
    end

    assign q_full    = (cnt_q == cnt_t'(LDQ_DEPTH));
    assign q_empty   = (cnt_q == '0);
    assign mem_ready = !q_full && !skid_vld_q && !(!mem_is_load && mem_rd_wren && waw_busy);
    assign acc       = mem_valid && mem_ready;
    assign push      = acc && mem_is_load;
    assign alu_acc   = acc && !mem_is_load;
    assign pop       = ld_rsp_valid && !q_empty;
    assign head_ent  = ent_q[head_q];

    wb_load_align u_align (
        .word_i    (ld_rsp_data),
        .addr_lo_i (head_ent.addr_lo),
        .funct3_i  (head_ent.funct3),
        .data_o    (ld_data)
    );

    always_comb begin
        vld_d = vld_q;
        if (pop)  vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
        cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end

    // Load responses own the port whenever valid; an ALU result arriving
    // alongside parks in the skid and retires once the port is free.
    always_comb begin
        rd_wren_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        skid_vld_d  = skid_vld_q;
        skid_wren_d = skid_wren_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        if (ld_rsp_valid) begin
            if (pop) begin
                rd_wren_d = head_ent.wren && (head_ent.rd != ZERO);
                rd_addr_d = head_ent.rd;
                rd_data_d = ld_data;
            end
            if (alu_acc) begin
                skid_vld_d  = 1'b1;
                skid_wren_d = mem_rd_wren;
                skid_rd_d   = mem_rd_addr;
                skid_data_d = mem_alu_data;
            end
        end else if (skid_vld_q) begin
            rd_wren_d  = skid_wren_q && (skid_rd_q != ZERO);
            rd_addr_d  = skid_rd_q;
            rd_data_d  = skid_data_q;
            skid_vld_d = 1'b0;
        end else if (alu_acc) begin
            rd_wren_d = mem_rd_wren && (mem_rd_addr != ZERO);
            rd_addr_d = mem_rd_addr;
            rd_data_d = mem_alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            skid_vld_q  <= 1'b0;
            skid_wren_q <= 1'b0;
            skid_rd_q   <= ZERO;
            skid_data_q <= NULL;
            rd_wren_q   <= 1'b0;
            rd_addr_q   <= ZERO;
            rd_data_q   <= NULL;
            err_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            cnt_q       <= cnt_d;
            if (pop)  head_q <= head_q + ptr_t'(1);
            if (push) tail_q <= tail_q + ptr_t'(1);
            skid_vld_q  <= skid_vld_d;
            skid_wren_q <= skid_wren_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            rd_wren_q   <= rd_wren_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            if (ld_rsp_valid && q_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ent_q[tail_q] <= '{rd: mem_rd_addr, wren: mem_rd_wren,
                                     funct3: mem_funct3, addr_lo: mem_addr_lo};
    end

    assign rd_wren = rd_wren_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;
    assign wb_err  = err_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] retire_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (rd_wren_q)               retire_cnt_q <= retire_cnt_q + 32'd1;
            if (mem_valid && !mem_ready) stall_cnt_q  <= stall_cnt_q + 32'd1;
        end
    end

    assign wb_retire_cnt = retire_cnt_q;
    assign wb_stall_cnt  = stall_cnt_q;
`else
    assign wb_retire_cnt = '0;
    assign wb_stall_cnt  = '0;
`endif

endmodule
